// File: rtl/run_controller.sv
// Run sequencer: holds the core in reset, runs it until pc hits FIN_ADDR
// or a cycle limit, then streams a data-memory window over valid/ready.
module run_controller #(
  parameter int unsigned HOLD_CYCLES = 2,
  parameter logic [31:0] FIN_ADDR    = 32'h000000bc,
  parameter int unsigned MAX_CYCLES  = 50000,
  parameter logic [31:0] DUMP_BASE   = 32'h00000400,
  parameter int unsigned DUMP_WORDS  = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] pc,
  output logic        core_reset,
  output logic [31:0] dump_addr,
  input  logic [31:0] dump_rdata,
  output logic [31:0] dump_data,
  output logic        dump_valid,
  input  logic        dump_ready,
  output logic        busy,
  output logic        done,
  output logic        fail,
  output logic [31:0] cycles
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOLD,
    S_RUN,
    S_DUMP,
    S_DONE,
    S_FAIL
  } state_t;

  localparam logic [31:0] HOLD_LAST = 32'(HOLD_CYCLES) - 32'd1;
  localparam logic [31:0] DUMP_LAST = 32'(DUMP_WORDS) - 32'd1;
  localparam logic [31:0] MAX_C     = 32'(MAX_CYCLES);

  state_t      state, state_n;
  logic [31:0] cycles_q, cycles_n;
  logic [31:0] hold_q, hold_n;
  logic [31:0] idx_q, idx_n;
  logic [31:0] cyc_inc;

  // saturating run-cycle increment
  assign cyc_inc = (cycles_q == 32'hFFFFFFFF) ? cycles_q : cycles_q + 32'd1;

  always_comb begin
    state_n  = state;
    cycles_n = cycles_q;
    hold_n   = hold_q;
    idx_n    = idx_q;
    unique case (state)
      S_IDLE, S_DONE, S_FAIL: begin
        if (start) begin
          cycles_n = '0;
          hold_n   = '0;
          idx_n    = '0;
          state_n  = (HOLD_CYCLES == 0) ? S_RUN : S_HOLD;
        end
      end
      S_HOLD: begin
        if (hold_q == HOLD_LAST) state_n = S_RUN;
        else hold_n = hold_q + 32'd1;
      end
      S_RUN: begin
        cycles_n = cyc_inc;
        // a pc match beats the limit on the same edge
        if (pc == FIN_ADDR)
          state_n = (DUMP_WORDS == 0) ? S_DONE : S_DUMP;
        else if (cyc_inc >= MAX_C)
          state_n = S_FAIL;
      end
      S_DUMP: begin
        if (dump_ready) begin
          idx_n = idx_q + 32'd1;
          if (idx_q == DUMP_LAST) state_n = S_DONE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      cycles_q <= '0;
      hold_q   <= '0;
      idx_q    <= '0;
    end else begin
      state    <= state_n;
      cycles_q <= cycles_n;
      hold_q   <= hold_n;
      idx_q    <= idx_n;
    end
  end

  assign core_reset = (state != S_RUN);
  assign busy       = (state == S_HOLD) || (state == S_RUN) ||
                      (state == S_DUMP);
  assign done       = (state == S_DONE);
  assign fail       = (state == S_FAIL);
  assign dump_valid = (state == S_DUMP);
  assign dump_addr  = DUMP_BASE + (idx_q << 2);
  assign dump_data  = dump_rdata;
  assign cycles     = cycles_q;

endmodule

// File: tb/tb_run_controller.sv
// Directed bench for run_controller: default, short-timeout and
// zero-hold/zero-dump instances share one clock.
module tb_run_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [31:0] FIN  = 32'h000000bc;
  localparam logic [31:0] BASE = 32'h00000400;
  localparam logic [31:0] KEY  = 32'hDEAD0000;

  // instance A: default parameters
  logic        reset_a, start_a, ready_a;
  logic [31:0] pc_a, rdata_a, addr_a, data_a, cycles_a;
  logic        core_reset_a, valid_a, busy_a, done_a, fail_a;
  assign rdata_a = addr_a ^ KEY;

  run_controller u_a (
    .clk(clk), .reset(reset_a), .start(start_a), .pc(pc_a),
    .core_reset(core_reset_a), .dump_addr(addr_a),
    .dump_rdata(rdata_a), .dump_data(data_a), .dump_valid(valid_a),
    .dump_ready(ready_a), .busy(busy_a), .done(done_a),
    .fail(fail_a), .cycles(cycles_a)
  );

  // instance B: MAX_CYCLES = 100
  logic        reset_b, start_b, ready_b;
  logic [31:0] pc_b, rdata_b, addr_b, data_b, cycles_b;
  logic        core_reset_b, valid_b, busy_b, done_b, fail_b;
  assign rdata_b = addr_b ^ KEY;

  run_controller #(.MAX_CYCLES(100)) u_b (
    .clk(clk), .reset(reset_b), .start(start_b), .pc(pc_b),
    .core_reset(core_reset_b), .dump_addr(addr_b),
    .dump_rdata(rdata_b), .dump_data(data_b), .dump_valid(valid_b),
    .dump_ready(ready_b), .busy(busy_b), .done(done_b),
    .fail(fail_b), .cycles(cycles_b)
  );

  // instance C: HOLD_CYCLES = 0, DUMP_WORDS = 0
  logic        reset_c, start_c, ready_c;
  logic [31:0] pc_c, rdata_c, addr_c, data_c, cycles_c;
  logic        core_reset_c, valid_c, busy_c, done_c, fail_c;
  assign rdata_c = addr_c ^ KEY;

  run_controller #(.HOLD_CYCLES(0), .DUMP_WORDS(0)) u_c (
    .clk(clk), .reset(reset_c), .start(start_c), .pc(pc_c),
    .core_reset(core_reset_c), .dump_addr(addr_c),
    .dump_rdata(rdata_c), .dump_data(data_c), .dump_valid(valid_c),
    .dump_ready(ready_c), .busy(busy_c), .done(done_c),
    .fail(fail_c), .cycles(cycles_c)
  );

  // stimulus only: start A, release pc=FIN on the run_len-th RUN cycle
  task automatic run_a(input int run_len, output int hold_seen,
                       output int low_cnt);
    int g;
    start_a = 1'b1;
    pc_a    = 32'h0;
    @(negedge clk);
    start_a   = 1'b0;
    hold_seen = 0;
    g = 0;
    while (core_reset_a && g < 20) begin
      hold_seen++;
      g++;
      @(negedge clk);
    end
    low_cnt = 0;
    g = 0;
    while (!core_reset_a && g < 200) begin
      low_cnt++;
      g++;
      if (low_cnt == run_len) pc_a = FIN;
      @(negedge clk);
    end
    pc_a = 32'h0;
  endtask

  // stimulus only: start B, match at match_at (0 = never)
  task automatic run_b(input int match_at, output int low_cnt,
                       output bit saw_valid);
    int g;
    saw_valid = 1'b0;
    start_b = 1'b1;
    pc_b    = 32'h0;
    @(negedge clk);
    start_b = 1'b0;
    g = 0;
    while (core_reset_b && g < 20) begin
      if (valid_b) saw_valid = 1'b1;
      g++;
      @(negedge clk);
    end
    low_cnt = 0;
    g = 0;
    while (!core_reset_b && g < 300) begin
      if (valid_b) saw_valid = 1'b1;
      low_cnt++;
      g++;
      if (low_cnt == match_at) pc_b = FIN;
      @(negedge clk);
    end
    pc_b = 32'h0;
  endtask

  task automatic test_reset;
    n_checks++;
    if (core_reset_a !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_core_reset got %b exp 1", core_reset_a);
    end
    n_checks++;
    if ({busy_a, done_a, fail_a, valid_a} !== 4'b0000) begin
      n_fail++;
      $display("FAIL rst_flags got %b exp 0000",
               {busy_a, done_a, fail_a, valid_a});
    end
    n_checks++;
    if (cycles_a !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_cycles got %h exp 0", cycles_a);
    end
    n_checks++;
    if (addr_a !== BASE) begin
      n_fail++;
      $display("FAIL rst_addr got %h exp %h", addr_a, BASE);
    end
  endtask

  task automatic test_nominal;
    int hs, lc, n, t;
    logic [31:0] ea;
    run_a(40, hs, lc);
    n_checks++;
    if (hs !== 2) begin
      n_fail++;
      $display("FAIL nom_hold got %0d exp 2", hs);
    end
    n_checks++;
    if (lc !== 40) begin
      n_fail++;
      $display("FAIL nom_run_len got %0d exp 40", lc);
    end
    n_checks++;
    if (valid_a !== 1'b1 || cycles_a !== 32'd40) begin
      n_fail++;
      $display("FAIL nom_enter_dump got v=%b c=%0d exp v=1 c=40",
               valid_a, cycles_a);
    end
    ready_a = 1'b1;
    n = 0;
    t = 0;
    while (valid_a && t < 50) begin
      ea = BASE + 32'(4 * n);
      n_checks++;
      if (addr_a !== ea || data_a !== (ea ^ KEY)) begin
        n_fail++;
        $display("FAIL nom_word%0d got %h/%h exp %h/%h",
                 n, addr_a, data_a, ea, ea ^ KEY);
      end
      n++;
      t++;
      @(negedge clk);
    end
    ready_a = 1'b0;
    n_checks++;
    if (t !== 6) begin
      n_fail++;
      $display("FAIL nom_dump_cycles got %0d exp 6", t);
    end
    n_checks++;
    if (done_a !== 1'b1 || busy_a !== 1'b0 || cycles_a !== 32'd40) begin
      n_fail++;
      $display("FAIL nom_done got d=%b b=%b c=%0d exp d=1 b=0 c=40",
               done_a, busy_a, cycles_a);
    end
  endtask

  task automatic test_backpressure;
    int hs, lc, n, t;
    int pat [4] = '{1, 0, 0, 1};
    logic [31:0] ea;
    run_a(10, hs, lc);
    n = 0;
    t = 0;
    while (valid_a && t < 100) begin
      ready_a = pat[t % 4][0];
      ea = BASE + 32'(4 * n);
      n_checks++;
      if (addr_a !== ea || data_a !== (ea ^ KEY)) begin
        n_fail++;
        $display("FAIL bp_t%0d got %h/%h exp %h/%h",
                 t, addr_a, data_a, ea, ea ^ KEY);
      end
      if (ready_a) n++;
      t++;
      @(negedge clk);
    end
    ready_a = 1'b0;
    n_checks++;
    if (n !== 6 || done_a !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_transfers got n=%0d d=%b exp n=6 d=1", n, done_a);
    end
  endtask

  task automatic test_reset_mid_dump;
    int hs, lc, n, t;
    logic [31:0] ea;
    run_a(5, hs, lc);
    ready_a = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (addr_a !== 32'h0000040c || valid_a !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_before got %h v=%b exp 0000040c v=1",
               addr_a, valid_a);
    end
    reset_a = 1'b1;
    ready_a = 1'b0;
    @(negedge clk);
    reset_a = 1'b0;
    n_checks++;
    if (valid_a !== 1'b0 || addr_a !== BASE || busy_a !== 1'b0 ||
        cycles_a !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_after got v=%b a=%h b=%b c=%0d exp 0 %h 0 0",
               valid_a, addr_a, busy_a, cycles_a, BASE);
    end
    run_a(7, hs, lc);
    ready_a = 1'b1;
    n = 0;
    t = 0;
    while (valid_a && t < 50) begin
      ea = BASE + 32'(4 * n);
      n_checks++;
      if (addr_a !== ea || data_a !== (ea ^ KEY)) begin
        n_fail++;
        $display("FAIL mid_rerun%0d got %h exp %h", n, addr_a, ea);
      end
      n++;
      t++;
      @(negedge clk);
    end
    ready_a = 1'b0;
    n_checks++;
    if (n !== 6 || done_a !== 1'b1 || cycles_a !== 32'd7) begin
      n_fail++;
      $display("FAIL mid_rerun_end got n=%0d d=%b c=%0d exp 6 1 7",
               n, done_a, cycles_a);
    end
  endtask

  task automatic test_timeout;
    int lc;
    bit sv;
    run_b(0, lc, sv);
    n_checks++;
    if (lc !== 100) begin
      n_fail++;
      $display("FAIL to_run_len got %0d exp 100", lc);
    end
    n_checks++;
    if (fail_b !== 1'b1 || done_b !== 1'b0 || busy_b !== 1'b0 ||
        core_reset_b !== 1'b1) begin
      n_fail++;
      $display("FAIL to_flags got f=%b d=%b b=%b cr=%b exp 1 0 0 1",
               fail_b, done_b, busy_b, core_reset_b);
    end
    n_checks++;
    if (cycles_b !== 32'd100 || sv !== 1'b0) begin
      n_fail++;
      $display("FAIL to_cycles got c=%0d v=%b exp c=100 v=0",
               cycles_b, sv);
    end
    @(negedge clk);
    n_checks++;
    if (cycles_b !== 32'd100 || fail_b !== 1'b1) begin
      n_fail++;
      $display("FAIL to_hold got c=%0d f=%b exp 100 1", cycles_b, fail_b);
    end
  endtask

  task automatic test_simultaneous;
    int lc, t;
    bit sv;
    run_b(100, lc, sv);
    n_checks++;
    if (valid_b !== 1'b1 || fail_b !== 1'b0 || cycles_b !== 32'd100 ||
        lc !== 100) begin
      n_fail++;
      $display("FAIL sim_dump got v=%b f=%b c=%0d l=%0d exp 1 0 100 100",
               valid_b, fail_b, cycles_b, lc);
    end
    ready_b = 1'b1;
    t = 0;
    while (valid_b && t < 50) begin
      t++;
      @(negedge clk);
    end
    ready_b = 1'b0;
    n_checks++;
    if (t !== 6 || done_b !== 1'b1) begin
      n_fail++;
      $display("FAIL sim_done got t=%0d d=%b exp 6 1", t, done_b);
    end
  endtask

  task automatic test_edge_params;
    bit sv;
    sv = 1'b0;
    start_c = 1'b1;
    pc_c = 32'h0;
    @(negedge clk);
    if (valid_c) sv = 1'b1;
    n_checks++;
    if (core_reset_c !== 1'b0 || busy_c !== 1'b1 || cycles_c !== 32'h0) begin
      n_fail++;
      $display("FAIL edge_run got cr=%b b=%b c=%0d exp 0 1 0",
               core_reset_c, busy_c, cycles_c);
    end
    start_c = 1'b1;
    @(negedge clk);
    if (valid_c) sv = 1'b1;
    start_c = 1'b0;
    n_checks++;
    if (core_reset_c !== 1'b0 || cycles_c !== 32'd1) begin
      n_fail++;
      $display("FAIL edge_busy_start got cr=%b c=%0d exp 0 1",
               core_reset_c, cycles_c);
    end
    pc_c = FIN;
    @(negedge clk);
    if (valid_c) sv = 1'b1;
    pc_c = 32'h0;
    n_checks++;
    if (done_c !== 1'b1 || busy_c !== 1'b0 || cycles_c !== 32'd2 ||
        sv !== 1'b0) begin
      n_fail++;
      $display("FAIL edge_done got d=%b b=%b c=%0d v=%b exp 1 0 2 0",
               done_c, busy_c, cycles_c, sv);
    end
    reset_c = 1'b1;
    start_c = 1'b1;
    @(negedge clk);
    reset_c = 1'b0;
    start_c = 1'b0;
    n_checks++;
    if (busy_c !== 1'b0 || done_c !== 1'b0 || core_reset_c !== 1'b1) begin
      n_fail++;
      $display("FAIL edge_rst_prio got b=%b d=%b cr=%b exp 0 0 1",
               busy_c, done_c, core_reset_c);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_a = 1'b1; start_a = 1'b0; pc_a = 32'h0; ready_a = 1'b0;
    reset_b = 1'b1; start_b = 1'b0; pc_b = 32'h0; ready_b = 1'b0;
    reset_c = 1'b1; start_c = 1'b0; pc_c = 32'h0; ready_c = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    reset_a = 1'b0;
    reset_b = 1'b0;
    reset_c = 1'b0;
    @(negedge clk);
    test_nominal();
    test_backpressure();
    test_reset_mid_dump();
    test_timeout();
    test_simultaneous();
    test_edge_params();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
